test_harness_monitor: RTL

Per-test supervisor that sits around each generated test module (clock/reset in, fail/finish out).
- Upstream: sequences the test's reset, holding it for a fixed number of cycles after global reset.
- Downstream: consumes the test's fail/finish flags and latches a sticky verdict: pass, fail or timeout.
- Reports the run length in cycles. CI top levels read done/pass/fail/timeout.

---
 rtl/test_harness_monitor.sv | 96 +++++++++
 1 files changed

// File: rtl/test_harness_monitor.sv
// Per-test supervisor: sequences the test's reset, then watches fail/finish
// and latches a sticky pass/fail/timeout verdict together with the run length.
module test_harness_monitor #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CYCLE_W        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               test_fail,
  input  logic               test_finish,
  output logic               test_reset,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycles
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                fail_seen_reg, fail_seen_next;
  logic [CYCLE_W-1:0]  cycles_reg, cycles_next;

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    fail_seen_next = fail_seen_reg;
    cycles_next    = cycles_reg;
    case (state_reg)
      S_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = S_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (cycles_reg != {CYCLE_W{1'b1}}) begin
          cycles_next = cycles_reg + 1'b1;
        end
        fail_seen_next = fail_seen_reg | test_fail;
        // Finish takes priority over the timeout on the last allowed cycle.
        if (test_finish) begin
          state_next = (fail_seen_reg | test_fail) ? S_FAIL : S_PASS;
        end else if (cycles_reg == TIMEOUT_LAST) begin
          state_next = S_TIMEOUT;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_HOLD;
      hold_cnt_reg  <= '0;
      fail_seen_reg <= 1'b0;
      cycles_reg    <= '0;
      test_reset    <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      fail_seen_reg <= fail_seen_next;
      cycles_reg    <= cycles_next;
      // Outputs decode the next state so they line up with the state register.
      test_reset    <= (state_next == S_HOLD);
      done          <= (state_next == S_PASS) || (state_next == S_FAIL) ||
                       (state_next == S_TIMEOUT);
      pass          <= (state_next == S_PASS);
      fail          <= (state_next == S_FAIL);
      timeout       <= (state_next == S_TIMEOUT);
    end
  end

  assign cycles = cycles_reg;

endmodule
